// File: rtl/fpu_div_seq.sv
// Multi-cycle IEEE-754 single-precision divider (radix-2 restoring, round-to-nearest-even, FTZ).
// Optional exception flag outputs are built when FPU_DIV_FLAGS_EN is defined.
module fpu_div_seq #(
  parameter int QBITS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
`ifdef FPU_DIV_FLAGS_EN
  ,
  output logic        flag_invalid,
  output logic        flag_div_zero,
  output logic        flag_overflow,
  output logic        flag_underflow,
  output logic        flag_inexact
`endif
);

  localparam int CW = $clog2(QBITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(QBITS - 1);
  localparam logic [QBITS-1:0] STK_MASK = (QBITS'(1) << (QBITS - 25)) - QBITS'(1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_DIV,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t state;

  logic [31:0]        a_r, b_r;
  logic               sign_r;
  logic signed [9:0]  exp_r;
  logic [23:0]        mb_r;
  logic [24:0]        rem_r;
  logic [QBITS-1:0]   q_r;
  logic [CW-1:0]      cnt_r;
  logic               spec_r;
  logic [31:0]        spec_val_r;
  logic [23:0]        sig_r;
  logic               guard_r;
  logic               sticky_r;

  function automatic logic rne_inc(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

  // Saturate to inf on overflow, flush to zero on underflow, else pack.
  function automatic logic [31:0] pack_sat(input logic s, input logic signed [9:0] e,
                                           input logic [23:0] m);
    if (e >= 10'sd255)
      return {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)
      return {s, 31'd0};
    else
      return {s, e[7:0], m[22:0]};
  endfunction

  // Operand classification for the special-case override.
  logic [7:0]  ea, eb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        inv_c, dz_c, inf_c, zero_c, spec_c, sign_c;
  logic [31:0] spec_val_c;

  always_comb begin
    ea     = a_r[30:23];
    eb     = b_r[30:23];
    sign_c = a_r[31] ^ b_r[31];
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf  = (ea == 8'hFF) && (a_r[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b_r[22:0] == 23'd0);
    a_nan  = (ea == 8'hFF) && (a_r[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b_r[22:0] != 23'd0);
    inv_c  = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
    dz_c   = b_zero & ~a_zero & ~a_inf & ~a_nan;
    inf_c  = ~inv_c & (a_inf | dz_c);
    zero_c = ~inv_c & (a_zero | b_inf);
    spec_c = inv_c | inf_c | zero_c;
    if (inv_c)
      spec_val_c = QNAN;
    else if (inf_c)
      spec_val_c = {sign_c, 8'hFF, 23'd0};
    else
      spec_val_c = {sign_c, 31'd0};
  end

  // Trial subtraction for one restoring step; bit 25 is the borrow.
  logic [25:0] diff;
  assign diff = {1'b0, rem_r} - {2'b00, mb_r};

  // Rounding of the normalized significand.
  logic              inc;
  logic [24:0]       sum;
  logic [23:0]       sig_rnd;
  logic signed [9:0] exp_rnd;

  always_comb begin
    inc     = rne_inc(sig_r[0], guard_r, sticky_r);
    sum     = {1'b0, sig_r} + {24'd0, inc};
    sig_rnd = sum[24] ? sum[24:1] : sum[23:0];
    exp_rnd = sum[24] ? (exp_r + 10'sd1) : exp_r;
  end

  // Normalization source: shift out a leading zero quotient bit.
  logic [QBITS-1:0] qn;
  assign qn = q_r[QBITS-1] ? q_r : (q_r << 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      out        <= 32'd0;
      a_r        <= 32'd0;
      b_r        <= 32'd0;
      sign_r     <= 1'b0;
      exp_r      <= 10'sd0;
      mb_r       <= 24'd0;
      rem_r      <= 25'd0;
      q_r        <= '0;
      cnt_r      <= '0;
      spec_r     <= 1'b0;
      spec_val_r <= 32'd0;
      sig_r      <= 24'd0;
      guard_r    <= 1'b0;
      sticky_r   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            busy  <= 1'b1;
            state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign_r     <= sign_c;
          exp_r      <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
          mb_r       <= {1'b1, b_r[22:0]};
          rem_r      <= {2'b01, a_r[22:0]};
          q_r        <= '0;
          cnt_r      <= '0;
          spec_r     <= spec_c;
          spec_val_r <= spec_val_c;
          state      <= S_DIV;
        end
        S_DIV: begin
          if (!diff[25]) begin
            rem_r <= diff[24:0] << 1;
            q_r   <= {q_r[QBITS-2:0], 1'b1};
          end else begin
            rem_r <= rem_r << 1;
            q_r   <= {q_r[QBITS-2:0], 1'b0};
          end
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CNT_LAST)
            state <= S_NORM;
        end
        S_NORM: begin
          sig_r    <= qn[QBITS-1 -: 24];
          guard_r  <= qn[QBITS-25];
          sticky_r <= (|(qn & STK_MASK)) | (rem_r != 25'd0);
          if (!q_r[QBITS-1])
            exp_r <= exp_r - 10'sd1;
          state <= S_ROUND;
        end
        S_ROUND: begin
          out   <= spec_r ? spec_val_r : pack_sat(sign_r, exp_rnd, sig_rnd);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FPU_DIV_FLAGS_EN
  logic spec_inv_r, spec_dz_r;
  logic ovf_c, unf_c;

  assign ovf_c = (exp_rnd >= 10'sd255);
  assign unf_c = (exp_rnd <= 10'sd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_inv_r     <= 1'b0;
      spec_dz_r      <= 1'b0;
      flag_invalid   <= 1'b0;
      flag_div_zero  <= 1'b0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_inexact   <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        flag_invalid   <= 1'b0;
        flag_div_zero  <= 1'b0;
        flag_overflow  <= 1'b0;
        flag_underflow <= 1'b0;
        flag_inexact   <= 1'b0;
      end
      if (state == S_UNPACK) begin
        spec_inv_r <= inv_c;
        spec_dz_r  <= dz_c;
      end
      if (state == S_ROUND) begin
        if (spec_r) begin
          flag_invalid   <= spec_inv_r;
          flag_div_zero  <= spec_dz_r;
          flag_overflow  <= 1'b0;
          flag_underflow <= 1'b0;
          flag_inexact   <= 1'b0;
        end else begin
          flag_invalid   <= 1'b0;
          flag_div_zero  <= 1'b0;
          flag_overflow  <= ovf_c;
          flag_underflow <= unf_c;
          flag_inexact   <= guard_r | sticky_r | ovf_c | unf_c;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fpu_div_seq.sv
// Directed bench for fpu_div_seq: scoreboarded results, latency/busy/done timing, abort by reset.
module tb_fpu_div_seq;

  localparam int QBITS = 26;
  localparam int LAT   = QBITS + 3;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] out;
`ifdef FPU_DIV_FLAGS_EN
  logic flag_invalid, flag_div_zero, flag_overflow, flag_underflow, flag_inexact;
`endif

  fpu_div_seq #(.QBITS(QBITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .out   (out)
`ifdef FPU_DIV_FLAGS_EN
    ,
    .flag_invalid   (flag_invalid),
    .flag_div_zero  (flag_div_zero),
    .flag_overflow  (flag_overflow),
    .flag_underflow (flag_underflow),
    .flag_inexact   (flag_inexact)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flags;  // {invalid, div_zero, overflow, underflow, inexact}
    string       tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Count done pulses over n cycles; none expected.
  task automatic quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk({tag, " extra_done"}, 32'(seen), 32'd0);
  endtask

  // Drive one operation; if inject > 0 a second start is pulsed that many cycles in.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [31:0] eres, input logic [4:0] eflags,
                        input string tag, input int inject);
    int   lat, busy_low;
    bit   got;
    exp_t e;
    sb.push_back('{eres, eflags, tag});
    @(posedge clk); #1;
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_low = 0; got = 0;
    while (!got && lat < LAT + 20) begin
      if (done) begin
        got = 1;
      end else begin
        if (!busy) busy_low++;
        if (inject > 0 && lat == inject) begin
          a = 32'h3F80_0000; b = 32'h4040_0000; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        lat++;
      end
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(LAT));
    chk({tag, " busy_during"}, 32'(busy_low), 32'd0);
    chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    e = sb.pop_front();
    if (got) begin
      chk({e.tag, " out"}, out, e.res);
`ifdef FPU_DIV_FLAGS_EN
      chk({e.tag, " flags"},
          {27'd0, flag_invalid, flag_div_zero, flag_overflow, flag_underflow, flag_inexact},
          {27'd0, e.flags});
`endif
    end
    quiet(tag, (inject > 0) ? LAT + 6 : 3);
    chk({tag, " out_held"}, out, e.res);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out", out, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000, "6/2", 0);
    run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 5'b00001, "1/3", 0);
    run_op(32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB, 5'b00001, "2/3", 0);
    run_op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 5'b00000, "1/1", 0);
    run_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 5'b01000, "1/0", 0);
    run_op(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 5'b01000, "-1/0", 0);
    run_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 5'b10000, "0/0", 0);
    run_op(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 5'b10000, "inf/inf", 0);
    run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 5'b10000, "nan/1", 0);
    run_op(32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 5'b00000, "inf/2", 0);
    run_op(32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 5'b00000, "2/-inf", 0);
    run_op(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 5'b00000, "-0/2", 0);
    run_op(32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 5'b00000, "sub/1", 0);
    run_op(32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 5'b00101, "ovf", 0);
    run_op(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 5'b00011, "unf", 0);
    run_op(32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 5'b00000, "-6/2 second_start", 5);

    // Asynchronous reset in the middle of the iteration loop.
    @(posedge clk); #1;
    a = 32'h40C0_0000; b = 32'h4000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort out", out, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    quiet("abort", LAT + 6);
    run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000, "after_abort", 0);

    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
